// File: rtl/ad9361_pkg.sv
// ---------------------------------------------------------------------------
// ad9361_pkg
// Shared types and defaults for the AD9361 RX burst controller.
//   burst_state_t : ENSM sequencing states of the burst controller
//   DEFAULT_*     : default pulse / settle / timeout / count widths
//   cnt_width()   : counter width able to hold 0 .. n-1
// ---------------------------------------------------------------------------
package ad9361_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAKE    = 3'd1,
    ST_ARM     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SLEEP   = 3'd4,
    ST_DONE    = 3'd5
  } burst_state_t;

  localparam int DEFAULT_PULSE_CYCLES   = 4;
  localparam int DEFAULT_SETTLE_CYCLES  = 64;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
  localparam int DEFAULT_COUNT_WIDTH    = 16;

  // Width of a counter that runs from 0 up to n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ad9361_enable_pulse.sv
// ---------------------------------------------------------------------------
// ad9361_enable_pulse
// Turns a single-cycle start strobe into a registered ENABLE pulse exactly
// PULSE_CYCLES wide, plus a strobe during the pulse's final cycle.
// Shared by the WAKE (ALERT->RX) and SLEEP (RX->ALERT) pulses.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_start        : start (or restart) a pulse; enable rises next cycle
//   o_enable       : registered ENABLE pin drive
//   o_pulse_done   : high during the last cycle of the pulse
// ---------------------------------------------------------------------------
module ad9361_enable_pulse
  import ad9361_pkg::*;
#(
  parameter int PULSE_CYCLES = DEFAULT_PULSE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  output logic o_enable,
  output logic o_pulse_done
);

  localparam int CW = cnt_width(PULSE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PULSE_CYCLES - 1);

  logic          r_active;
  logic [CW-1:0] r_cnt;

  // A start arriving in the final cycle of a pulse restarts it, so a WAKE
  // pulse can run straight into a SLEEP pulse without enable dropping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
    end else if (r_active) begin
      if (r_cnt == LAST) begin
        r_active <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_enable     = r_active;
  assign o_pulse_done = r_active && (r_cnt == LAST);

endmodule

// File: rtl/ad9361_rx_burst_ctrl.sv
// ---------------------------------------------------------------------------
// ad9361_rx_burst_ctrl
// Drives a single AD9361 through pulse-mode ENSM transitions (ALERT->RX->
// ALERT) and gates a fixed-length burst of channel-0 samples.
// Optional feature macro: AD9361_BURST_TIMEOUT_EN (CAPTURE idle timeout).
//   i_clk, i_rst          : sample clock, asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready/i_cmd_count : burst request handshake
//   i_abort               : single-cycle abort request
//   i_valid_0, i_valid_1  : sample strobes from the RX interface
//   o_gate_0, o_gate_1    : qualified strobes for downstream capture
//   o_enable, o_txnrx     : AD9361 control pins (txnrx fixed at 0 = RX)
//   o_busy                : high whenever not idle
//   o_done                : one-cycle completion pulse
//   o_aborted, o_timeout  : burst status, valid while o_done is high
// ---------------------------------------------------------------------------
module ad9361_rx_burst_ctrl
  import ad9361_pkg::*;
#(
  parameter int PULSE_CYCLES   = DEFAULT_PULSE_CYCLES,
  parameter int SETTLE_CYCLES  = DEFAULT_SETTLE_CYCLES,
  parameter int COUNT_WIDTH    = DEFAULT_COUNT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [COUNT_WIDTH-1:0] i_cmd_count,
  input  logic                   i_abort,
  input  logic                   i_valid_0,
  input  logic                   i_valid_1,
  output logic                   o_gate_0,
  output logic                   o_gate_1,
  output logic                   o_enable,
  output logic                   o_txnrx,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_aborted,
  output logic                   o_timeout
);

  localparam int SW = cnt_width(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  burst_state_t           r_state;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic [SW-1:0]          r_settle;
  logic                   r_abort_pend;
  logic                   r_aborted;

  logic w_capture;
  logic w_last_sample;
  logic w_pulse_done;
  logic w_wake_start;
  logic w_sleep_start;
  logic w_timeout_hit;

  assign w_capture     = (r_state == ST_CAPTURE);
  assign w_last_sample = w_capture && i_valid_0 &&
                         (r_remaining == COUNT_WIDTH'(1));

`ifdef AD9361_BURST_TIMEOUT_EN
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_idle;
  logic          r_timeout;

  // Counts consecutive CAPTURE cycles without a channel-0 sample; it sits
  // at zero outside CAPTURE so every capture phase starts fresh.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idle <= '0;
    end else if (!w_capture || i_valid_0) begin
      r_idle <= '0;
    end else if (r_idle != TIMEOUT_LAST) begin
      r_idle <= r_idle + TW'(1);
    end
  end

  assign w_timeout_hit = w_capture && !i_valid_0 && (r_idle == TIMEOUT_LAST);
  assign o_timeout     = r_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign o_timeout     = 1'b0;
`endif

  // Pulse starts are decoded from the same conditions the FSM uses so that
  // enable rises on the very edge that enters WAKE or SLEEP.
  assign w_wake_start  = (r_state == ST_IDLE) && i_cmd_valid &&
                         (i_cmd_count != '0);
  assign w_sleep_start = ((r_state == ST_WAKE) && w_pulse_done &&
                          (r_abort_pend || i_abort)) ||
                         ((r_state == ST_ARM) && i_abort) ||
                         (w_capture && (i_abort || w_timeout_hit)) ||
                         w_last_sample;

  ad9361_enable_pulse #(
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_pulse (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (w_wake_start || w_sleep_start),
    .o_enable    (o_enable),
    .o_pulse_done(w_pulse_done)
  );

  // Burst sequencer. The final sample wins over a simultaneous abort, so a
  // burst that completed is never reported as aborted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_remaining  <= '0;
      r_settle     <= '0;
      r_abort_pend <= 1'b0;
      r_aborted    <= 1'b0;
`ifdef AD9361_BURST_TIMEOUT_EN
      r_timeout    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_abort_pend <= 1'b0;
          if (i_cmd_valid) begin
            r_remaining <= i_cmd_count;
            r_aborted   <= 1'b0;
`ifdef AD9361_BURST_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
            r_state     <= (i_cmd_count == '0) ? ST_DONE : ST_WAKE;
          end
        end
        ST_WAKE: begin
          if (i_abort) begin
            r_abort_pend <= 1'b1;
          end
          if (w_pulse_done) begin
            if (r_abort_pend || i_abort) begin
              r_aborted <= 1'b1;
              r_state   <= ST_SLEEP;
            end else begin
              r_settle  <= '0;
              r_state   <= ST_ARM;
            end
          end
        end
        ST_ARM: begin
          if (i_abort) begin
            r_aborted <= 1'b1;
            r_state   <= ST_SLEEP;
          end else if (r_settle == SETTLE_LAST) begin
            r_state   <= ST_CAPTURE;
          end else begin
            r_settle  <= r_settle + SW'(1);
          end
        end
        ST_CAPTURE: begin
          if (i_valid_0 && (r_remaining != '0)) begin
            r_remaining <= r_remaining - COUNT_WIDTH'(1);
          end
          if (w_last_sample) begin
            r_state   <= ST_SLEEP;
          end else if (i_abort) begin
            r_aborted <= 1'b1;
            r_state   <= ST_SLEEP;
          end
`ifdef AD9361_BURST_TIMEOUT_EN
          else if (w_timeout_hit) begin
            r_timeout <= 1'b1;
            r_state   <= ST_SLEEP;
          end
`endif
        end
        ST_SLEEP: begin
          if (w_pulse_done) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_aborted   = r_aborted;
  assign o_txnrx     = 1'b0;
  assign o_gate_0    = w_capture && i_valid_0;
  assign o_gate_1    = w_capture && i_valid_1;

endmodule

// File: doc/ad9361_rx_burst_ctrl.md
# ad9361_rx_burst_ctrl

Sequences a single AD9361 through pulse-mode ENSM transitions (ALERT→RX→ALERT) and gates a fixed-length burst of received samples. It drives the `enable`/`txnrx` control pins in place of the free-running power-on enable logic in the CMOS RX interface, and sits between the host command path and that interface. Both blocks run on the same sample clock.

## Interface
- `PULSE_CYCLES`, 4: width of each ENABLE pulse in `clk` cycles (≥1).
- `SETTLE_CYCLES`, 64: wait after the entry pulse before samples are counted (≥1).
- `COUNT_WIDTH`, 16: width of the burst sample count.
- `TIMEOUT_CYCLES`, 1024: maximum number of consecutive CAPTURE cycles with `valid_0` low.

- `clk` in 1: sample clock (same domain as interface outputs).
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: burst request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_count` in COUNT_WIDTH: number of channel-0 samples to pass.
- `abort` in 1: single-cycle abort request.
- `valid_0`, `valid_1` in 1: sample strobes from the RX interface.
- `gate_0`, `gate_1` out 1: qualified strobes for downstream capture.
- `enable`, `txnrx` out 1: AD9361 control pins.
- `busy` out 1: high when not in IDLE.
- `done` out 1: one-cycle completion pulse.
- `aborted`, `timeout` out 1: status, valid while `done` is high.

## Operation
- States: IDLE, WAKE, ARM, CAPTURE, SLEEP, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, latch `cmd_count`.
  - Count 0 → DONE directly; `enable` is never pulsed.
  - Nonzero count → WAKE.
- **WAKE**: `enable`=1 for exactly PULSE_CYCLES, then → ARM.
- **ARM**: wait SETTLE_CYCLES with the gates closed, then → CAPTURE.
- **CAPTURE**
  - `gate_0`=`valid_0`, `gate_1`=`valid_1`, both combinational from registered state.
  - Each cycle with `valid_0`=1 decrements the remaining count.
  - When the last sample is gated, → SLEEP. A `valid_1` in the same cycle is still gated; later ones are not.
- **SLEEP**: `enable`=1 for PULSE_CYCLES, then → DONE.
- **DONE**: `done`=1 for one cycle, status flags held, then → IDLE.
- `txnrx` is constant 0.
- `abort`
  - In ARM or CAPTURE: immediately → SLEEP with `aborted`=1.
  - In WAKE: the pulse completes, then → SLEEP with `aborted`=1.
  - In SLEEP, DONE or IDLE: ignored.
- `abort` and the final sample in the same cycle: the sample is gated; `aborted`=0.
- Counter arithmetic is unsigned with no wrap; the remaining count saturates at 0.

## Timing
- Reset values: `enable`=0, `txnrx`=0, `cmd_ready`=1, `busy`=0, `done`=0, `aborted`=0, `timeout`=0, `gate_*`=0, state IDLE.
- `rst` asserted mid-burst forces IDLE asynchronously and drops `enable` at once. No SLEEP pulse is issued; software re-inits the ENSM.
- Handshake at edge T (nonzero count):
  - `enable` high T+1…T+PULSE_CYCLES.
  - ARM T+PULSE_CYCLES+1…T+PULSE_CYCLES+SETTLE_CYCLES.
  - First gatable cycle is T+PULSE_CYCLES+SETTLE_CYCLES+1.
- Last sample at edge S: `enable` high S+1…S+PULSE_CYCLES, `done` at S+PULSE_CYCLES+1, `cmd_ready` at S+PULSE_CYCLES+2.
- `cmd_count`=0 at T: `done` at T+1.

## Configuration
- `AD9361_BURST_TIMEOUT_EN` defined:
  - The CAPTURE idle counter is reset by every `valid_0`.
  - Reaching TIMEOUT_CYCLES → SLEEP with `timeout`=1.
- Undefined: no counter is built, `timeout` is tied to 0, and CAPTURE waits indefinitely.

## Structure
- Package `ad9361_pkg`: state enum `burst_state_t`, default PULSE/SETTLE/TIMEOUT constants.
- Sub-module `ad9361_enable_pulse`: start strobe in → fixed-width `enable` pulse plus a `pulse_done` strobe. It is used for both the WAKE and SLEEP pulses.

## Test plan
- Count=8, PULSE=4, SETTLE=64, `valid_0` every 2nd cycle:
  - `enable` high 4 cycles twice.
  - Exactly 8 `gate_0` pulses.
  - `done` 5 cycles after the 8th sample; `aborted`=`timeout`=0.
- Count=0: `done` one cycle after the handshake; `enable` never rises.
- `abort` during ARM: SLEEP pulse follows, zero gates, `done`+`aborted`=1.
- `abort` on the same cycle as the final sample: sample gated, `aborted`=0.
- With `AD9361_BURST_TIMEOUT_EN` and TIMEOUT=16, `valid_0` stopped after 3 samples of 8: `timeout`=1 and `done` after 16 idle cycles + SLEEP pulse.
- `rst` asserted mid-CAPTURE: `enable`, `gate_*` and `busy` are 0 immediately; `cmd_ready`=1 after release.
